data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed data memory for the RISC-V core's MEM stage.
- Replaces the word-per-address array with real byte lanes and full load/store-width handling: SB/SH/SW stores and LB/LH/LW/LBU/LHU loads.
- Adds misalignment and range checking, plus a valid/ready request and fixed-latency response handshake.
- Accepts one outstanding transaction at a time.

Parameters:
- ADDR_W, 32: request address width in bits.
- DEPTH_WORDS, 256: number of 32-bit words. Must be a power of 2 and at least 4.
- READ_LAT, 1: cycles from request acceptance to response, legal range 1..4. Applies to loads and stores alike.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or reserved-size request; valid when rsp_valid = 1.

Behaviour:
- Addressing:
  - word index = req_addr[log2(DEPTH_WORDS)+1:2]; lane = req_addr[1:0].
  - Out of range when any req_addr bit above log2(DEPTH_WORDS)+1 is set.
- Error conditions: size 11; half with addr[0] = 1; word with addr[1:0] != 0; out of range.
  - An errored request still completes the handshake.
  - It never writes memory; rsp_err = 1, rsp_rdata = 0.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. On req_valid, latch the request (we, size, unsigned, addr, wdata) and compute err.
    - If READ_LAT = 1, go to RESP; otherwise go to WAIT with cnt = READ_LAT-1.
  - WAIT: req_ready = 0. Decrement cnt each cycle; go to RESP when cnt reaches 1.
  - RESP: rsp_valid = 1 for exactly one cycle, req_ready = 0, then go to IDLE.
  - The next request is therefore accepted no earlier than the cycle after RESP.
  - Throughput: one transaction per READ_LAT+1 cycles.
- Store commit:
  - Memory is written on the acceptance edge (IDLE and req_valid and req_we and no error).
  - Only the addressed byte lanes change: SB writes lane addr[1:0] with wdata[7:0]; SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; SW writes all four lanes.
  - Unaddressed lanes keep their previous value.
- Load data:
  - Memory is read from the word captured at acceptance; the lane is selected by the latched addr[1:0] and placed in the low bits.
  - Byte/half are extended per the latched req_unsigned. Word ignores req_unsigned.
- Store-then-load: a load accepted after a store's RESP sees the stored data. There is no overlap case because only one transaction is outstanding.
- Reset:
  - Outputs reset to req_ready = 0 during rst, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. FSM returns to IDLE and cnt = 0.
  - Reset mid-transaction aborts it with no response. A store already committed at acceptance stays written.
  - Memory contents are not cleared by reset unless DMEM_PRELOAD_EN is defined.
- Outside RESP: rsp_rdata and rsp_err are held at 0.

Optional Feature:
- DMEM_PRELOAD_EN defined: while rst = 1, every word is cleared and then preloaded:
  - word 4 = 32'h0000FF3C, word 5 = 32'h0000000F, word 6 = 32'h000000F3, word 7 = 32'h00FFEE3C.
- Undefined: reset leaves memory untouched and contents are X until written. No clearing logic is synthesised.

Test Plan:
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid exactly READ_LAT cycles after acceptance.
- After the above, SB 0x7A to 0x12, then LW 0x10 -> 0xDE7ABEEF. LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE.
- SH 0x8001 to 0x16, then LH 0x16 -> 0xFFFF8001, LHU 0x16 -> 0x00008001. LW 0x14 upper half = 0x8001.
- SW to 0x11, LH at 0x13, size 11 at 0x20, LW at address DEPTH_WORDS*4 -> each gives rsp_err = 1, rsp_rdata = 0. A follow-up LW of 0x10 shows memory unchanged.
- READ_LAT = 3, back-to-back req_valid held high -> req_ready low for 3 cycles after acceptance, one rsp_valid pulse per request, accept spacing 4 cycles.
- Assert rst during WAIT -> no rsp_valid, outputs 0, FSM IDLE. With DMEM_PRELOAD_EN, LW 0x1C after reset -> 0x00FFEE3C and LHU 0x10 -> 0x0000FF3C.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the MEM stage: SB/SH/SW stores, LB/LH/LW/LBU/LHU loads, one outstanding request.
// Define DMEM_PRELOAD_EN to clear and preload the array while rst is high.
module data_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_cnt, w_cnt_next;
  logic             w_accept;
  logic             w_oor;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             r_we, r_unsigned, r_err;
  logic [1:0]       r_size, r_lane;
  logic [31:0]      w_rword;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_data;

`ifdef DMEM_PRELOAD_EN
  function automatic logic [7:0] preload_byte(input int wi, input int lane);
    logic [31:0] v;
    case (wi)
      4:       v = 32'h0000FF3C;
      5:       v = 32'h0000000F;
      6:       v = 32'h000000F3;
      7:       v = 32'h00FFEE3C;
      default: v = 32'h00000000;
    endcase
    return v[8*lane +: 8];
  endfunction
`endif

  assign w_idx  = req_addr[IDX_W+1:2];
  assign w_lane = req_addr[1:0];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_oor
      assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_err = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || w_oor;

  // One byte-wide RAM per lane; stores touch only the lanes they address.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] r_mem [DEPTH_WORDS];
      logic [7:0] r_rbyte;
      logic [7:0] w_wbyte;
      logic       w_we;

      assign w_we = w_accept && req_we && !w_err &&
                    ((req_size == 2'b10) ||
                     (req_size == 2'b01 && w_lane[1] == LANE[1]) ||
                     (req_size == 2'b00 && w_lane == LANE));

      assign w_wbyte = (req_size == 2'b10) ? req_wdata[8*gi +: 8] :
                       (req_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                             req_wdata[7:0];

      always_ff @(posedge clk) begin
`ifdef DMEM_PRELOAD_EN
        if (rst) begin
          for (int wi = 0; wi < DEPTH_WORDS; wi++) begin
            r_mem[wi] <= preload_byte(wi, gi);
          end
        end else if (w_we) begin
`else
        if (w_we) begin
`endif
          r_mem[w_idx] <= w_wbyte;
        end
      end

      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_rbyte <= r_mem[w_idx];
        end
      end

      assign w_rword[8*gi +: 8] = r_rbyte;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_lane     <= w_lane;
      r_err      <= w_err;
    end
  end

  always_comb begin
    case (r_lane)
      2'b00:   w_byte = w_rword[7:0];
      2'b01:   w_byte = w_rword[15:8];
      2'b10:   w_byte = w_rword[23:16];
      default: w_byte = w_rword[31:24];
    endcase
    w_half = r_lane[1] ? w_rword[31:16] : w_rword[15:0];
    case (r_size)
      2'b00:   w_load_data = {{24{!r_unsigned && w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{!r_unsigned && w_half[15]}}, w_half};
      default: w_load_data = w_rword;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = !rst;
        w_accept  = req_valid && !rst;
        if (w_accept) begin
          if (READ_LAT == 1) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = 3'(READ_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        rsp_err      = r_err;
        rsp_rdata    = (r_err || r_we) ? 32'h0 : w_load_data;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a transaction-level byte-array model predicts every response,
// and a per-cycle compare process checks the handshake and response outputs against it.
module tb_data_mem_ctrl;

  localparam int LAT   = 3;
  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_mem [NB];
  int         cyc = 0;
  int         next_free = 0;
  int         n_total = 0;
  int         n_pass = 0;
  int         n_txn = 0;
  logic       chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
`ifdef DMEM_PRELOAD_EN
    {m_mem[19], m_mem[18], m_mem[17], m_mem[16]} = 32'h0000FF3C;
    {m_mem[23], m_mem[22], m_mem[21], m_mem[20]} = 32'h0000000F;
    {m_mem[27], m_mem[26], m_mem[25], m_mem[24]} = 32'h000000F3;
    {m_mem[31], m_mem[30], m_mem[29], m_mem[28]} = 32'h00FFEE3C;
`endif
  endtask

  // Access of n bytes: legal only if naturally aligned and inside the array.
  task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
    int     n;
    longint v;
    n     = 1 << size;
    err   = (size == 2'b11) || ((addr % n) != 0) || (addr >= NB);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < n; k++) m_mem[addr + k] = wdata[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(m_mem[addr + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic hold,
                       output logic [31:0] rdata, output logic err);
    exp_t e;
    while (cyc < next_free) tick();
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    model_req(we, size, uns, addr, wdata, rdata, err);
    e.acc   = cyc;
    e.rdata = rdata;
    e.err   = err;
    q.push_back(e);
    next_free = cyc + LAT + 1;
    n_txn++;
    $display("txn %0d cyc %0d: %s size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h err=%0b",
             n_txn, cyc, we ? "ST" : "LD", size, uns, addr, wdata, rdata, err);
    tick();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic ld(input string name, input logic [1:0] size, input logic uns,
                    input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    issue(1'b0, size, uns, addr, 32'h0, 1'b0, d, e);
    check({name, "_data"}, d, exp_data);
    check({name, "_err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  task automatic st(input string name, input logic [1:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic hold, input logic exp_err);
    logic [31:0] d;
    logic        e;
    issue(1'b1, size, 1'b0, addr, wdata, hold, d, e);
    check({name, "_err"}, {31'h0, e}, {31'h0, exp_err});
  endtask

  // Per-cycle comparison of all DUT outputs against the model's outstanding transaction.
  logic        c_busy, c_ready, c_valid, c_err;
  logic [31:0] c_rdata;
  always @(negedge clk) begin
    if (chk_en) begin
      c_busy  = (q.size() > 0) && (cyc > q[0].acc);
      c_ready = !rst && !c_busy;
      c_valid = (q.size() > 0) && (cyc == q[0].acc + LAT);
      c_rdata = c_valid ? q[0].rdata : 32'h0;
      c_err   = c_valid ? q[0].err : 1'b0;
      check("req_ready", {31'h0, req_ready}, {31'h0, c_ready});
      check("rsp_valid", {31'h0, rsp_valid}, {31'h0, c_valid});
      check("rsp_rdata", rsp_rdata, c_rdata);
      check("rsp_err", {31'h0, rsp_err}, {31'h0, c_err});
      if (c_valid) void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    model_reset();
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    next_free = cyc;

    // Word store/load round trip
    st("sw_10", 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
    ld("lw_10", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Byte lane update and extensions
    st("sb_12", 2'b00, 32'h12, 32'hFFFFFF7A, 1'b0, 1'b0);
    ld("lw_10b", 2'b10, 1'b0, 32'h10, 32'hDE7ABEEF, 1'b0);
    ld("lb_13", 2'b00, 1'b0, 32'h13, 32'hFFFFFFDE, 1'b0);
    ld("lbu_13", 2'b00, 1'b1, 32'h13, 32'h000000DE, 1'b0);
    ld("lb_12", 2'b00, 1'b0, 32'h12, 32'h0000007A, 1'b0);
    ld("lh_10", 2'b01, 1'b0, 32'h10, 32'hFFFFBEEF, 1'b0);

    // Upper half store
    st("sw_14", 2'b10, 32'h14, 32'h00000000, 1'b0, 1'b0);
    st("sh_16", 2'b01, 32'h16, 32'hAAAA8001, 1'b0, 1'b0);
    ld("lh_16", 2'b01, 1'b0, 32'h16, 32'hFFFF8001, 1'b0);
    ld("lhu_16", 2'b01, 1'b1, 32'h16, 32'h00008001, 1'b0);
    ld("lw_14", 2'b10, 1'b0, 32'h14, 32'h80010000, 1'b0);

    // Error cases never touch memory
    st("sw_00", 2'b10, 32'h0, 32'h01020304, 1'b0, 1'b0);
    st("sw_11_mis", 2'b10, 32'h11, 32'h11223344, 1'b0, 1'b1);
    ld("lh_13_mis", 2'b01, 1'b0, 32'h13, 32'h0, 1'b1);
    ld("rsv_20", 2'b11, 1'b0, 32'h20, 32'h0, 1'b1);
    ld("lw_oor", 2'b10, 1'b0, DEPTH * 4, 32'h0, 1'b1);
    st("sw_oor", 2'b10, DEPTH * 4, 32'hBAD0BAD0, 1'b0, 1'b1);
    st("sb_oor", 2'b00, 32'h8000_0001, 32'h000000AA, 1'b0, 1'b1);
    ld("lw_10c", 2'b10, 1'b0, 32'h10, 32'hDE7ABEEF, 1'b0);
    ld("lw_00", 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0);

    // Back-to-back with req_valid held high
    st("b2b_sw_40", 2'b10, 32'h40, 32'h00000055, 1'b1, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, d, e);
    check("b2b_lw_40_data", d, 32'h00000055);
    st("b2b_sw_44", 2'b10, 32'h44, 32'hCAFEF00D, 1'b1, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h47, 32'h0, 1'b1, d, e);
    check("b2b_lbu_47_data", d, 32'h000000CA);
    issue(1'b0, 2'b01, 1'b0, 32'h44, 32'h0, 1'b0, d, e);
    check("b2b_lh_44_data", d, 32'hFFFFF00D);

    // Reset while a committed store waits for its response
    st("sw_48", 2'b10, 32'h48, 32'h12345678, 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
`ifdef DMEM_PRELOAD_EN
    model_reset();
`endif
    tick();
    tick();
    rst = 1'b0;
    next_free = cyc;

`ifdef DMEM_PRELOAD_EN
    ld("pre_lw_1c", 2'b10, 1'b0, 32'h1C, 32'h00FFEE3C, 1'b0);
    ld("pre_lhu_10", 2'b01, 1'b1, 32'h10, 32'h0000FF3C, 1'b0);
    ld("pre_lb_11", 2'b00, 1'b0, 32'h11, 32'hFFFFFFFF, 1'b0);
    ld("pre_lw_48", 2'b10, 1'b0, 32'h48, 32'h00000000, 1'b0);
`else
    ld("rst_lw_48", 2'b10, 1'b0, 32'h48, 32'h12345678, 1'b0);
    ld("rst_lw_10", 2'b10, 1'b0, 32'h10, 32'hDE7ABEEF, 1'b0);
`endif

    while (cyc < next_free) tick();
    tick();
    chk_en = 1'b0;
    check("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
